// File: rtl/demux_pkg.sv
// ============================================================================
// Module : demux_pkg
// Brief  : Shared constants for the 1-to-4 stream demultiplexer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package demux_pkg;

  localparam int CH_N  = 4;
  localparam int SEL_W = 2;

  // Channel indices use the same {s1,s0} encoding as the 4:1 mux path
  localparam logic [SEL_W-1:0] CH0 = 2'd0;
  localparam logic [SEL_W-1:0] CH1 = 2'd1;
  localparam logic [SEL_W-1:0] CH2 = 2'd2;
  localparam logic [SEL_W-1:0] CH3 = 2'd3;

endpackage

`default_nettype wire

// File: rtl/demux_slot.sv
// ============================================================================
// Module : demux_slot
// Brief  : One-entry output register slice with valid flag and drain counter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_slot
  import demux_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [W-1:0]     din,
  input  logic             ready,
  output logic             valid,
  output logic [W-1:0]     dout,
  output logic [CNT_W-1:0] cnt
);

  logic             r_valid;
  logic [W-1:0]     r_data;
  logic [CNT_W-1:0] r_cnt;
  logic             w_drain;

  assign w_drain = r_valid && ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      // A reload wins over a drain so the slot stays full on back-to-back words
      if (load) begin
        r_data  <= din;
        r_valid <= 1'b1;
      end else if (w_drain) begin
        r_valid <= 1'b0;
      end
      if (w_drain) begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign valid = r_valid;
  assign dout  = r_data;
  assign cnt   = r_cnt;

endmodule

`default_nettype wire

// File: rtl/demux14_4_stream.sv
// ============================================================================
// Module : demux14_4_stream
// Brief  : Registered 1-to-4 valid/ready demultiplexer, select or round-robin.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux14_4_stream
  import demux_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic             s0,
  input  logic             s1,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [W-1:0]     e0,
  output logic [W-1:0]     e1,
  output logic [W-1:0]     e2,
  output logic [W-1:0]     e3,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
);

  logic [SEL_W-1:0] r_rr_ptr;
  logic [SEL_W-1:0] w_tgt;
  logic             w_in_ready;
  logic             w_accept;
  logic [CH_N-1:0]  w_load;
  logic [CH_N-1:0]  w_valid;
  logic [W-1:0]     w_dout [CH_N];
  logic [CNT_W-1:0] w_cnt  [CH_N];

  assign w_tgt      = mode ? r_rr_ptr : {s1, s0};
  assign w_in_ready = !reset && (!w_valid[w_tgt] || out_ready[w_tgt]);
  assign w_accept   = in_valid && w_in_ready;

  // Pointer only advances on round-robin accepts; manual mode leaves it parked
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= CH0;
    end else if (w_accept && mode) begin
      r_rr_ptr <= r_rr_ptr + 2'd1;
    end
  end

  generate
    for (genvar k = 0; k < CH_N; k++) begin : g_slot
      localparam logic [SEL_W-1:0] c_idx = SEL_W'(k);

      assign w_load[k] = w_accept && (w_tgt == c_idx);

      demux_slot #(
        .W     (W),
        .CNT_W (CNT_W)
      ) u_slot (
        .clk   (clk),
        .reset (reset),
        .load  (w_load[k]),
        .din   (in_data),
        .ready (out_ready[k]),
        .valid (w_valid[k]),
        .dout  (w_dout[k]),
        .cnt   (w_cnt[k])
      );
    end
  endgenerate

  assign in_ready  = w_in_ready;
  assign out_valid = w_valid;
  assign e0        = w_dout[CH0];
  assign e1        = w_dout[CH1];
  assign e2        = w_dout[CH2];
  assign e3        = w_dout[CH3];
  assign cnt0      = w_cnt[CH0];
  assign cnt1      = w_cnt[CH1];
  assign cnt2      = w_cnt[CH2];
  assign cnt3      = w_cnt[CH3];

endmodule

`default_nettype wire

// File: tb/tb_demux14_4_stream.sv
// ============================================================================
// Module : tb_demux14_4_stream
// Brief  : Directed table-driven bench for demux14_4_stream.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux14_4_stream;

  logic       clk;
  logic       reset;
  logic       mode;
  logic       s0;
  logic       s1;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [3:0] e0, e1, e2, e3;
  logic [7:0] cnt0, cnt1, cnt2, cnt3;

  int checks = 0;
  int errors = 0;

  demux14_4_stream #(.W(4), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .s0        (s0),
    .s1        (s1),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .e0        (e0),
    .e1        (e1),
    .e2        (e2),
    .e3        (e3),
    .cnt0      (cnt0),
    .cnt1      (cnt1),
    .cnt2      (cnt2),
    .cnt3      (cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        md;
    logic [1:0]  sel;
    logic        iv;
    logic [3:0]  din;
    logic [3:0]  ordy;
    logic        x_ir;
    logic [3:0]  x_ov;
    logic [15:0] x_e;    // {e3,e2,e1,e0}
    logic [31:0] x_cnt;  // {cnt3,cnt2,cnt1,cnt0}
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic md, input logic [1:0] sel, input logic iv,
                       input logic [3:0] din, input logic [3:0] ordy);
    reset     = rst;
    mode      = md;
    {s1, s0}  = sel;
    in_valid  = iv;
    in_data   = din;
    out_ready = ordy;
  endtask

  initial begin
    //         rst   md    sel   iv    din    ordy     ir    ov       e         cnt
    tbl[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 4'h0, 4'b0000, 1'b0, 4'b0000, 16'h0000, 32'h00000000};
    tbl[1]  = '{1'b0, 1'b0, 2'd2, 1'b1, 4'hA, 4'b0000, 1'b1, 4'b0100, 16'h0A00, 32'h00000000};
    tbl[2]  = '{1'b0, 1'b0, 2'd2, 1'b1, 4'hB, 4'b0000, 1'b0, 4'b0100, 16'h0A00, 32'h00000000};
    tbl[3]  = '{1'b0, 1'b0, 2'd1, 1'b1, 4'h3, 4'b0000, 1'b1, 4'b0110, 16'h0A30, 32'h00000000};
    tbl[4]  = '{1'b0, 1'b0, 2'd1, 1'b1, 4'h7, 4'b0010, 1'b1, 4'b0110, 16'h0A70, 32'h00000100};
    tbl[5]  = '{1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 4'b1111, 1'b1, 4'b0000, 16'h0A70, 32'h00010200};
    tbl[6]  = '{1'b1, 1'b0, 2'd0, 1'b0, 4'h0, 4'b0000, 1'b0, 4'b0000, 16'h0000, 32'h00000000};
    // round-robin sweep
    tbl[7]  = '{1'b0, 1'b1, 2'd0, 1'b1, 4'h1, 4'b1111, 1'b1, 4'b0001, 16'h0001, 32'h00000000};
    tbl[8]  = '{1'b0, 1'b1, 2'd0, 1'b1, 4'h2, 4'b1111, 1'b1, 4'b0010, 16'h0021, 32'h00000001};
    tbl[9]  = '{1'b0, 1'b1, 2'd0, 1'b1, 4'h3, 4'b1111, 1'b1, 4'b0100, 16'h0321, 32'h00000101};
    tbl[10] = '{1'b0, 1'b1, 2'd0, 1'b1, 4'h4, 4'b1111, 1'b1, 4'b1000, 16'h4321, 32'h00010101};
    tbl[11] = '{1'b0, 1'b1, 2'd0, 1'b1, 4'h5, 4'b1111, 1'b1, 4'b0001, 16'h4325, 32'h01010101};
    tbl[12] = '{1'b0, 1'b1, 2'd0, 1'b0, 4'h0, 4'b1111, 1'b1, 4'b0000, 16'h4325, 32'h01010102};
    // blocked channel isolation, then pointer held across manual-mode accepts
    tbl[13] = '{1'b0, 1'b0, 2'd3, 1'b1, 4'h9, 4'b0000, 1'b1, 4'b1000, 16'h9325, 32'h01010102};
    tbl[14] = '{1'b0, 1'b0, 2'd3, 1'b1, 4'h6, 4'b0000, 1'b0, 4'b1000, 16'h9325, 32'h01010102};
    tbl[15] = '{1'b0, 1'b0, 2'd0, 1'b1, 4'h6, 4'b0000, 1'b1, 4'b1001, 16'h9326, 32'h01010102};
    tbl[16] = '{1'b0, 1'b1, 2'd0, 1'b1, 4'hC, 4'b0000, 1'b1, 4'b1011, 16'h93C6, 32'h01010102};
    tbl[17] = '{1'b0, 1'b1, 2'd0, 1'b1, 4'hD, 4'b0000, 1'b1, 4'b1111, 16'h9DC6, 32'h01010102};
    // mid-operation reset with all slots full, then pointer restarts at channel 0
    tbl[18] = '{1'b1, 1'b1, 2'd0, 1'b1, 4'hF, 4'b1111, 1'b0, 4'b0000, 16'h0000, 32'h00000000};
    tbl[19] = '{1'b0, 1'b1, 2'd0, 1'b1, 4'hE, 4'b0000, 1'b1, 4'b0001, 16'h000E, 32'h00000000};

    drive(1'b1, 1'b0, 2'd0, 1'b0, 4'h0, 4'b0000);
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].rst, tbl[i].md, tbl[i].sel, tbl[i].iv, tbl[i].din, tbl[i].ordy);
      #1;
      chk("in_ready", i, 32'(in_ready), 32'(tbl[i].x_ir));
      @(posedge clk);
      #1;
      chk("out_valid", i, 32'(out_valid), 32'(tbl[i].x_ov));
      chk("e", i, {16'h0, e3, e2, e1, e0}, {16'h0, tbl[i].x_e});
      chk("cnt", i, {cnt3, cnt2, cnt1, cnt0}, tbl[i].x_cnt);
    end

    // Counter wrap: 257 back-to-back words into channel 0 give 256 drains
    drive(1'b1, 1'b0, 2'd0, 1'b0, 4'h0, 4'b0000);
    @(posedge clk);
    #1;
    for (int n = 1; n <= 257; n++) begin
      drive(1'b0, 1'b0, 2'd0, 1'b1, 4'(n), 4'b0001);
      #1;
      if (n == 1 || n == 257) chk("wrap_in_ready", n, 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      if (n == 256) chk("wrap_cnt0_255", n, 32'(cnt0), 32'd255);
    end
    chk("wrap_cnt0_0", 257, 32'(cnt0), 32'd0);
    chk("wrap_ov", 257, 32'(out_valid), 32'b0001);
    chk("wrap_e0", 257, 32'(e0), 32'(4'(257)));

    // Draining with no input leaves the slot empty and data held
    drive(1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 4'b0001);
    @(posedge clk);
    #1;
    chk("final_ov", 0, 32'(out_valid), 32'b0000);
    chk("final_cnt0", 0, 32'(cnt0), 32'd1);
    chk("final_e0", 0, 32'(e0), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
